// File: rtl/key_event.sv
// Key event detector: press/release pulses, single/double click, long press.
// Define KEY_EVENT_REPEAT_EN to re-pulse long_o every REPEAT_TICKS while held.
module key_event #(
  parameter int TICK_DIV     = 500000,
  parameter int LONG_TICKS   = 100,
  parameter int DCLICK_TICKS = 30,
  parameter int ACTIVE_LOW   = 1
`ifdef KEY_EVENT_REPEAT_EN
  ,
  parameter int REPEAT_TICKS = 20
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dclick_o,
  output logic long_o,
  output logic held_o
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  localparam logic REL = (ACTIVE_LOW != 0);

  logic        sync1;
  logic        sync2;
  logic        lvl;
  logic        lvl_prev;
  logic [1:0]  fill;
  logic        armed;
  logic        rise;
  logic        fall;
  logic [19:0] tick_cnt;
  logic        tick;
  logic [7:0]  cnt;
  logic        clr;
  logic        long_hit;
  logic        dclk_hit;
  state_t      state;
  state_t      state_n;
  logic        press_n;
  logic        release_n;
  logic        click_n;
  logic        dclick_n;
  logic        long_n;

  assign lvl = sync2 ^ REL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= REL;
      sync2 <= REL;
    end else begin
      sync1 <= key_i;
      sync2 <= sync1;
    end
  end

  // Edges are only honoured once a genuine released level has been seen,
  // so a key held across reset cannot produce a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill     <= 2'b00;
      armed    <= 1'b0;
      lvl_prev <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      held_o   <= 1'b0;
    end else begin
      fill     <= {fill[0], 1'b1};
      if (fill[1] && !lvl) begin
        armed <= 1'b1;
      end
      lvl_prev <= lvl;
      held_o   <= lvl;
      rise     <= armed & lvl & ~lvl_prev;
      fall     <= armed & ~lvl & lvl_prev;
    end
  end

  assign tick = (tick_cnt == 20'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= 20'd0;
    end else if (tick) begin
      tick_cnt <= 20'd0;
    end else begin
      tick_cnt <= tick_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (tick && (cnt != 8'hff)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign long_hit = (cnt >= 8'(LONG_TICKS));
  assign dclk_hit = (cnt >= 8'(DCLICK_TICKS));

`ifdef KEY_EVENT_REPEAT_EN
  logic rep_hit;
  assign rep_hit = (cnt >= 8'(REPEAT_TICKS));
`endif

  always_comb begin
    state_n   = state;
    clr       = 1'b0;
    press_n   = 1'b0;
    release_n = 1'b0;
    click_n   = 1'b0;
    dclick_n  = 1'b0;
    long_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESS1;
          press_n = 1'b1;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_n   = WAIT2;
          release_n = 1'b1;
        end else if (long_hit) begin
          state_n = LONG;
          long_n  = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          state_n = PRESS2;
          press_n = 1'b1;
        end else if (dclk_hit) begin
          state_n = IDLE;
          click_n = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
          dclick_n  = 1'b1;
        end else if (long_hit) begin
          state_n = LONG;
          long_n  = 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end
`ifdef KEY_EVENT_REPEAT_EN
        else if (rep_hit) begin
          long_n = 1'b1;
          clr    = 1'b1;
        end
`endif
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (state_n != state) begin
      clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      click_o   <= 1'b0;
      dclick_o  <= 1'b0;
      long_o    <= 1'b0;
    end else begin
      state     <= state_n;
      press_o   <= press_n;
      release_o <= release_n;
      click_o   <= click_n;
      dclick_o  <= dclick_n;
      long_o    <= long_n;
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: scenario table, tie sweep, random sequences
// against an event-level model, reset corner cases.
module tb_key_event;

  localparam int TD = 4;
  localparam int LT = 5;
  localparam int DT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_i = 1'b1;
  logic press_o, release_o, click_o, dclick_o, long_o, held_o;

  key_event #(
    .TICK_DIV(TD),
    .LONG_TICKS(LT),
    .DCLICK_TICKS(DT),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_i(key_i),
    .press_o(press_o),
    .release_o(release_o),
    .click_o(click_o),
    .dclick_o(dclick_o),
    .long_o(long_o),
    .held_o(held_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // kinds: 0 press, 1 release, 2 click, 3 dclick, 4 long
  typedef struct {
    int kind;
    int t;
  } ev_t;

  typedef struct {
    int kind;
    int t;
    int tol;
  } exp_t;

  ev_t  log_q[$];
  exp_t exp_q[$];
  bit   hist[$];
  int   valid = 0;
  int   held_err = 0;
  int   held_n = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      valid = 0;
      hist.delete();
    end else begin
      valid++;
      if (press_o)   log_q.push_back('{0, cyc});
      if (release_o) log_q.push_back('{1, cyc});
      if (click_o)   log_q.push_back('{2, cyc});
      if (dclick_o)  log_q.push_back('{3, cyc});
      if (long_o)    log_q.push_back('{4, cyc});
      hist.push_front(key_i == 1'b0);
      if (hist.size() > 3) void'(hist.pop_back());
      if (valid >= 3) begin
        held_n++;
        if (held_o !== hist[2]) held_err++;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int count_k(input int k);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].kind == k) n++;
    return n;
  endfunction

  function automatic int time_k(input int k);
    foreach (log_q[i]) if (log_q[i].kind == k) return log_q[i].t;
    return -1;
  endfunction

  // Drive the key (pressed or released) for n cycles from a negedge.
  task automatic set_key(input bit pressed, input int n, output int t);
    key_i = ~pressed;
    t = cyc;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int d1, g1, d2;
    int np, nr, nc, nd, nl;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tx;
    int st, p, r, d, g, lim, ok;
    int nl, nc, nd, relt, lngt;

    vecs[0] = '{8, 40, 0, 1, 1, 1, 0, 0};
    vecs[1] = '{8, 4, 8, 2, 2, 0, 1, 0};
    vecs[2] = '{40, 40, 0, 1, 1, 0, 0, 1};
    vecs[3] = '{8, 4, 30, 2, 2, 0, 0, 1};
    vecs[4] = '{6, 25, 6, 2, 2, 2, 0, 0};
    vecs[5] = '{1, 40, 0, 1, 1, 1, 0, 0};

    rst_n = 1'b0;
    key_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_press", press_o, 0);
    chk("rst_release", release_o, 0);
    chk("rst_click", click_o, 0);
    chk("rst_dclick", dclick_o, 0);
    chk("rst_long", long_o, 0);
    chk("rst_held", held_o, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_quiet", log_q.size(), 0);

    for (int i = 0; i < 6; i++) begin
      log_q.delete();
      set_key(1, vecs[i].d1, tx);
      set_key(0, vecs[i].g1, tx);
      if (vecs[i].d2 > 0) begin
        set_key(1, vecs[i].d2, tx);
        set_key(0, 40, tx);
      end
      chk($sformatf("vec%0d_press", i), count_k(0), vecs[i].np);
      chk($sformatf("vec%0d_release", i), count_k(1), vecs[i].nr);
      chk($sformatf("vec%0d_click", i), count_k(2), vecs[i].nc);
      chk($sformatf("vec%0d_dclick", i), count_k(3), vecs[i].nd);
      chk($sformatf("vec%0d_long", i), count_k(4), vecs[i].nl);
    end

    // Sweep hold length across the long-press threshold to hit the tie.
    for (int dd = 14; dd <= 26; dd++) begin
      log_q.delete();
      set_key(1, dd, t0);
      set_key(0, 40, t1);
      nl = count_k(4);
      nc = count_k(2);
      nd = count_k(3);
      relt = time_k(1);
      lngt = time_k(4);
      chk($sformatf("sweep%0d_press_t", dd), time_k(0), t0 + 4);
      chk($sformatf("sweep%0d_rel_t", dd), relt, t1 + 4);
      chk($sformatf("sweep%0d_class", dd), nl + nc, 1);
      chk($sformatf("sweep%0d_dclick", dd), nd, 0);
      if (nl == 1) chk($sformatf("sweep%0d_order", dd), int'(lngt < relt), 1);
    end

    // Random sequences checked against an event-level model.
    log_q.delete();
    exp_q.delete();
    st = 0;
    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(1, 0) ? $urandom_range(45, 24) : $urandom_range(14, 1);
      g = $urandom_range(1, 0) ? $urandom_range(30, 18) : $urandom_range(8, 1);
      if (i == 39) g = 40;
      set_key(1, d, t0);
      set_key(0, g, t1);
      p = t0 + 4;
      r = t1 + 4;
      exp_q.push_back('{0, p, 0});
      if (d >= 24) begin
        exp_q.push_back('{4, p + LT * TD, TD + 1});
        exp_q.push_back('{1, r, 0});
        st = 0;
      end else if (st == 1) begin
        exp_q.push_back('{1, r, 0});
        exp_q.push_back('{3, r, 0});
        st = 0;
      end else begin
        exp_q.push_back('{1, r, 0});
        st = 1;
      end
      if (st == 1 && g >= 18) begin
        exp_q.push_back('{2, r + DT * TD, TD + 1});
        st = 0;
      end
    end
    chk("rnd_count", log_q.size(), exp_q.size());
    lim = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      ok = (log_q[i].kind == exp_q[i].kind) &&
           (log_q[i].t >= exp_q[i].t - exp_q[i].tol) &&
           (log_q[i].t <= exp_q[i].t + exp_q[i].tol);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd_ev%0d got kind %0d t %0d want kind %0d t %0d tol %0d",
                 i, log_q[i].kind, log_q[i].t, exp_q[i].kind, exp_q[i].t,
                 exp_q[i].tol);
      end
    end

    // Reset while waiting for a second click.
    log_q.delete();
    set_key(1, 8, tx);
    set_key(0, 4, tx);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_press", press_o, 0);
    chk("midrst_release", release_o, 0);
    chk("midrst_click", click_o, 0);
    chk("midrst_dclick", dclick_o, 0);
    chk("midrst_long", long_o, 0);
    chk("midrst_held", held_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    repeat (40) @(negedge clk);
    chk("midrst_no_click", count_k(2), 0);
    chk("midrst_no_events", log_q.size(), 0);

    // Key held down across reset release.
    set_key(1, 10, tx);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    repeat (20) @(negedge clk);
    chk("heldrst_no_press", count_k(0), 0);
    set_key(0, 20, tx);
    log_q.delete();
    set_key(1, 8, t0);
    set_key(0, 40, tx);
    chk("heldrst_press_cnt", count_k(0), 1);
    chk("heldrst_press_t", time_k(0), t0 + 4);

    chk("held_track", held_err, 0);
    chk("held_seen", int'(held_n > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
